// File: rtl/conway_board_sequencer.sv
// Sequencer feeding the Game of Life cell array: drives the shared load/advance
// lines and watches the board to report generation count, stable and extinct.
//
// state | meaning
// LOAD0 | first seed-load cycle (cell_rst high)
// LOAD1 | second seed-load cycle (cell_rst high)
// IDLE  | paused; serves single steps, waits for run
// RUN   | free-run, one advance every TICKS_PER_GEN cycles
// HALT  | auto-halted on stable/extinct board; only load or rst leave
module conway_board_sequencer #(
  parameter int N             = 8,
  parameter int TICKS_PER_GEN = 12_000_000,
  parameter int GEN_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             load,
  input  logic             auto_halt,
  input  logic [N*N-1:0]   board_state,
  output logic             cell_rst,
  output logic             cell_ena,
  output logic [GEN_W-1:0] generation,
  output logic             stable,
  output logic             extinct,
  output logic             running
);

  localparam int TICK_W = (TICKS_PER_GEN > 2) ? $clog2(TICKS_PER_GEN) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_GEN - 1);
  localparam logic [GEN_W-1:0]  GEN_MAX   = '1;

  localparam logic [2:0] S_LOAD0 = 3'd0;
  localparam logic [2:0] S_LOAD1 = 3'd1;
  localparam logic [2:0] S_IDLE  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [GEN_W-1:0]  gen_q, gen_d;
  logic [N*N-1:0]    snap_q, snap_d;
  logic              stable_q, stable_d;
  logic              extinct_q, extinct_d;
  logic              eval_q, eval_d;
  logic              ena_q, ena_d;
  logic              cell_rst_q, cell_rst_d;
  logic              running_q, running_d;
  logic              halt_req;
  logic              serve_step;

  assign halt_req = auto_halt & (stable_q | extinct_q);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    gen_d      = gen_q;
    snap_d     = snap_q;
    stable_d   = stable_q;
    extinct_d  = extinct_q;
    eval_d     = 1'b0;
    serve_step = 1'b0;

    // Cells update on the edge ending an advance cycle; compare one cycle later.
    if (ena_q) begin
      snap_d = board_state;
      eval_d = 1'b1;
      if (gen_q != GEN_MAX) begin
        gen_d = gen_q + 1'b1;
      end
    end
    if (eval_q) begin
      stable_d  = (board_state == snap_q);
      extinct_d = (board_state == '0);
    end

    case (state_q)
      S_LOAD0: state_d = S_LOAD1;
      S_LOAD1: state_d = S_IDLE;
      S_IDLE: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (step && !ena_q) begin
          serve_step = 1'b1;
        end else if (run) begin
          state_d = S_RUN;
          tick_d  = '0;
        end
      end
      S_RUN: begin
        if (halt_req) begin
          state_d = S_HALT;
          tick_d  = '0;
        end else if (!run) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_LOAD0;
    endcase

    // A reload pulse overrides everything else in the same cycle.
    if (load) begin
      state_d    = S_LOAD0;
      tick_d     = '0;
      gen_d      = '0;
      stable_d   = 1'b0;
      extinct_d  = 1'b0;
      eval_d     = 1'b0;
      serve_step = 1'b0;
    end

    ena_d      = serve_step | ((state_d == S_RUN) && (tick_d == TICK_LAST));
    cell_rst_d = (state_d == S_LOAD0) || (state_d == S_LOAD1);
    running_d  = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LOAD0;
      tick_q     <= '0;
      gen_q      <= '0;
      snap_q     <= '0;
      stable_q   <= 1'b0;
      extinct_q  <= 1'b0;
      eval_q     <= 1'b0;
      ena_q      <= 1'b0;
      cell_rst_q <= 1'b1;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      gen_q      <= gen_d;
      snap_q     <= snap_d;
      stable_q   <= stable_d;
      extinct_q  <= extinct_d;
      eval_q     <= eval_d;
      ena_q      <= ena_d;
      cell_rst_q <= cell_rst_d;
      running_q  <= running_d;
    end
  end

  assign cell_rst   = cell_rst_q;
  assign cell_ena   = ena_q;
  assign generation = gen_q;
  assign stable     = stable_q;
  assign extinct    = extinct_q;
  assign running    = running_q;

endmodule

// File: tb/tb_conway_board_sequencer.sv
// Scoreboard bench for conway_board_sequencer on a 4x4 board with a small
// behavioural cell array (toggle, still-life or dying pattern).
module tb_conway_board_sequencer;

  localparam int N  = 4;
  localparam int T  = 4;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0, step = 1'b0, load = 1'b0, auto_halt = 1'b0;
  logic [N*N-1:0] board = '0;
  logic [1:0] mode = 2'd0;   // 0: toggle, 1: still life, 2: dies
  logic cell_rst, cell_ena, stable, extinct, running;
  logic [GW-1:0] generation;

  conway_board_sequencer #(.N(N), .TICKS_PER_GEN(T), .GEN_W(GW)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .load(load),
    .auto_halt(auto_halt), .board_state(board),
    .cell_rst(cell_rst), .cell_ena(cell_ena), .generation(generation),
    .stable(stable), .extinct(extinct), .running(running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cell_rst)
      board <= (mode == 2'd2) ? 16'h0020 : 16'h0660;
    else if (cell_ena)
      board <= (mode == 2'd0) ? (board ^ 16'hFFFF) : (mode == 2'd1) ? board : 16'h0000;
  end

  typedef struct packed {
    int         at;
    logic       cr;
    logic       ce;
    logic [1:0] g;
    logic       st;
    logic       ex;
    logic       rn;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    pulse_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic void push_exp(int at, string nm, int cr, int ce, int g, int st, int ex, int rn);
    exp_t e;
    int   i;
    e.at = at; e.cr = cr[0]; e.ce = ce[0]; e.g = g[1:0];
    e.st = st[0]; e.ex = ex[0]; e.rn = rn[0];
    i = 0;
    while (i < exp_q.size() && exp_q[i].at <= at) i++;
    exp_q.insert(i, e);
    nm_q.insert(i, nm);
  endfunction

  function automatic void compare(string nm, logic [6:0] act, logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d cr,ce,gen,st,ex,run got=%b required=%b", nm, cyc, act, req);
    end
  endfunction

  exp_t  mon_e;
  string mon_n;
  int    mon_p;

  always begin
    @(posedge clk);
    #2;
    if (pulse_q.size() > 0 && pulse_q[0] <= cyc) begin
      mon_p = pulse_q.pop_front();
      checks++;
      if (mon_p != cyc || cell_ena !== 1'b1) begin
        errors++;
        $display("FAIL cell_ena_pulse cyc=%0d got=%b required=1 at cyc %0d", cyc, cell_ena, mon_p);
      end
    end else if (cell_ena !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_cell_ena cyc=%0d got=%b required=0", cyc, cell_ena);
    end
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      mon_e = exp_q.pop_front();
      mon_n = nm_q.pop_front();
      if (mon_e.at < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s stale expectation for cyc %0d at cyc %0d", mon_n, mon_e.at, cyc);
      end else begin
        compare(mon_n, {cell_rst, cell_ena, generation, stable, extinct, running},
                {mon_e.cr, mon_e.ce, mon_e.g, mon_e.st, mon_e.ex, mon_e.rn});
      end
    end
  end

  task automatic nb(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    // Reset held for three clocks, then the two-cycle load sequence
    for (int k = 1; k <= 3; k++) push_exp(k, "reset_hold", 1, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    nb(3);
    rst = 1'b1;
    c = cyc;
    push_exp(c + 1, "load_seq", 1, 0, 0, 0, 0, 0);
    push_exp(c + 2, "load_done", 0, 0, 0, 0, 0, 0);
    nb(2);

    // Free run with toggling board, saturating generation count
    c = cyc;
    run = 1'b1;
    push_exp(c + 1,  "run_enter", 0, 0, 0, 0, 0, 1);
    push_exp(c + 3,  "run_pre",   0, 0, 0, 0, 0, 1);
    push_exp(c + 4,  "pulse1",    0, 1, 0, 0, 0, 1);
    push_exp(c + 5,  "gen1",      0, 0, 1, 0, 0, 1);
    push_exp(c + 8,  "pulse2",    0, 1, 1, 0, 0, 1);
    push_exp(c + 9,  "gen2",      0, 0, 2, 0, 0, 1);
    push_exp(c + 12, "pulse3",    0, 1, 2, 0, 0, 1);
    push_exp(c + 13, "gen3",      0, 0, 3, 0, 0, 1);
    push_exp(c + 16, "pulse4",    0, 1, 3, 0, 0, 1);
    push_exp(c + 17, "gen_sat",   0, 0, 3, 0, 0, 1);
    for (int k = 4; k <= 16; k += 4) pulse_q.push_back(c + k);
    nb(17);
    run = 1'b0;
    push_exp(cyc + 1, "run_exit",   0, 0, 3, 0, 0, 0);
    push_exp(cyc + 5, "idle_quiet", 0, 0, 3, 0, 0, 0);
    nb(5);

    // Reload, single step, step ignored in RUN
    c = cyc;
    load = 1'b1;
    push_exp(c + 1, "load_clr",  1, 0, 0, 0, 0, 0);
    push_exp(c + 3, "load_idle", 0, 0, 0, 0, 0, 0);
    nb(1); load = 1'b0; nb(2);
    c = cyc;
    step = 1'b1;
    pulse_q.push_back(c + 1);
    push_exp(c + 1, "step_pulse", 0, 1, 0, 0, 0, 0);
    push_exp(c + 2, "step_gen",   0, 0, 1, 0, 0, 0);
    push_exp(c + 3, "step_once",  0, 0, 1, 0, 0, 0);
    nb(1); step = 1'b0; nb(2);
    c = cyc;
    run = 1'b1;
    pulse_q.push_back(c + 4);
    push_exp(c + 3, "step_in_run", 0, 0, 1, 0, 0, 1);
    push_exp(c + 4, "run_pulse",   0, 1, 1, 0, 0, 1);
    push_exp(c + 5, "run_stop",    0, 0, 2, 0, 0, 0);
    nb(2); step = 1'b1; nb(1); step = 1'b0; nb(1);
    run = 1'b0;
    nb(1);

    // Step and load together: load wins; switch to still-life with auto-halt
    c = cyc;
    step = 1'b1; load = 1'b1; mode = 2'd1; auto_halt = 1'b1;
    push_exp(c + 1, "step_load",   1, 0, 0, 0, 0, 0);
    push_exp(c + 3, "reload_idle", 0, 0, 0, 0, 0, 0);
    nb(1); step = 1'b0; load = 1'b0; nb(2);

    c = cyc;
    step = 1'b1;
    pulse_q.push_back(c + 1);
    push_exp(c + 1, "still_pulse",  0, 1, 0, 0, 0, 0);
    push_exp(c + 2, "still_gen",    0, 0, 1, 0, 0, 0);
    push_exp(c + 3, "still_stable", 0, 0, 1, 1, 0, 0);
    push_exp(c + 5, "halt_step",    0, 0, 1, 1, 0, 0);
    push_exp(c + 8, "halt_run",     0, 0, 1, 1, 0, 0);
    push_exp(c + 12, "halt_hold",   0, 0, 1, 1, 0, 0);
    nb(1); step = 1'b0; nb(3);
    step = 1'b1; nb(1);
    step = 1'b0; run = 1'b1; nb(7);
    run = 1'b0;

    // Load out of HALT; switch to dying pattern without auto-halt
    c = cyc;
    load = 1'b1; mode = 2'd2; auto_halt = 1'b0;
    push_exp(c + 1, "halt_load", 1, 0, 0, 0, 0, 0);
    push_exp(c + 3, "die_idle",  0, 0, 0, 0, 0, 0);
    nb(1); load = 1'b0; nb(2);

    c = cyc;
    step = 1'b1;
    pulse_q.push_back(c + 1);
    pulse_q.push_back(c + 5);
    push_exp(c + 1, "die_pulse",  0, 1, 0, 0, 0, 0);
    push_exp(c + 3, "extinct",    0, 0, 1, 0, 1, 0);
    push_exp(c + 5, "ext_step",   0, 1, 1, 0, 1, 0);
    push_exp(c + 7, "ext_stable", 0, 0, 2, 1, 1, 0);
    nb(1); step = 1'b0; nb(3);
    step = 1'b1; nb(1);
    step = 1'b0; nb(2);

    // Asynchronous reset during an advance pulse in RUN
    c = cyc;
    run = 1'b1;
    pulse_q.push_back(c + 4);
    push_exp(c + 1, "rst_run",   0, 0, 2, 1, 1, 1);
    push_exp(c + 4, "rst_pulse", 0, 1, 2, 1, 1, 1);
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1 compare("async_rst", {cell_rst, cell_ena, generation, stable, extinct, running}, 7'b1000000);
    @(negedge clk);
    run = 1'b0;
    push_exp(cyc + 1, "rst_hold", 1, 0, 0, 0, 0, 0);
    nb(1);
    rst = 1'b1;
    push_exp(cyc + 1, "reload_a", 1, 0, 0, 0, 0, 0);
    push_exp(cyc + 2, "reload_b", 0, 0, 0, 0, 0, 0);
    nb(4);

    checks++;
    if (exp_q.size() != 0 || pulse_q.size() != 0) begin
      errors++;
      $display("FAIL leftover expectations got=%0d/%0d required=0/0", exp_q.size(), pulse_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
